// File: rtl/mem_pattern_scanner.sv
// Memory-bus initiator: loads a NUL-terminated pattern and text one char per word,
// counts overlapping pattern occurrences in the text and writes the count back.
module mem_pattern_scanner #(
  parameter logic [31:0] TEXT_BASE   = 32'h000,
  parameter logic [31:0] PAT_BASE    = 32'h200,
  parameter logic [31:0] RESULT_ADDR = 32'h3FC,
  parameter int unsigned MAX_PAT     = 8,
  parameter int unsigned MAX_TEXT    = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] Read_data,
  output logic [31:0] Address,
  output logic [31:0] Write_data,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        busy,
  output logic        done,
  output logic [15:0] count
);

  localparam int unsigned PW = $clog2(MAX_PAT + 1);
  localparam int unsigned AW = (MAX_PAT > 1) ? $clog2(MAX_PAT) : 1;
  localparam int unsigned KW = $clog2(MAX_TEXT + 1);

  typedef enum logic [2:0] {IDLE, LOAD_PAT, SCAN, WRITE, DONE} state_t;

  state_t         state, state_next;
  logic [PW-1:0]  j, plen;
  logic [KW-1:0]  k;
  logic [15:0]    cnt;
  logic [7:0]     pat      [MAX_PAT];
  logic [7:0]     win      [MAX_PAT];
  logic [7:0]     win_next [MAX_PAT];
  logic [7:0]     ch;
  logic [AW-1:0]  idx;
  logic           match, pat_end, text_end;
  logic           unused_hi;

  assign ch        = Read_data[7:0];
  assign unused_hi = ^Read_data[31:8];
  assign pat_end   = (ch == 8'h00) || (j == PW'(MAX_PAT));
  assign text_end  = (ch == 8'h00) || (k == KW'(MAX_TEXT));

  // Match is judged on the window as it will be after this char shifts in.
  always_comb begin
    win_next[0] = ch;
    for (int unsigned i = 1; i < MAX_PAT; i++) win_next[AW'(i)] = win[AW'(i - 1)];
    match = ((32'(k) + 32'd1) >= 32'(plen));
    idx   = '0;
    for (int unsigned m = 0; m < MAX_PAT; m++) begin
      if (m < 32'(plen)) begin
        idx = AW'(32'(plen) - 32'd1 - m);
        if (win_next[idx] != pat[AW'(m)]) match = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    Write_data = '0;
    busy       = (state != IDLE);
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = LOAD_PAT;
      LOAD_PAT: begin
        MemRead = 1'b1;
        Address = PAT_BASE + (32'(j) << 2);
        if (pat_end) state_next = (j == '0) ? WRITE : SCAN;
      end
      SCAN: begin
        MemRead = 1'b1;
        Address = TEXT_BASE + (32'(k) << 2);
        if (text_end) state_next = WRITE;
      end
      WRITE: begin
        MemWrite   = 1'b1;
        Address    = RESULT_ADDR;
        Write_data = {16'h0000, cnt};
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      j     <= '0;
      plen  <= '0;
      k     <= '0;
      cnt   <= '0;
      count <= '0;
      for (int unsigned i = 0; i < MAX_PAT; i++) begin
        pat[AW'(i)] <= '0;
        win[AW'(i)] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (start) begin
          j    <= '0;
          plen <= '0;
          k    <= '0;
          cnt  <= '0;
          for (int unsigned i = 0; i < MAX_PAT; i++) win[AW'(i)] <= '0;
        end
        LOAD_PAT: begin
          if (pat_end) begin
            plen <= j;
            k    <= '0;
          end else begin
            pat[AW'(j)] <= ch;
            j           <= j + PW'(1);
          end
        end
        SCAN: if (!text_end) begin
          for (int unsigned i = 0; i < MAX_PAT; i++) win[AW'(i)] <= win_next[AW'(i)];
          k <= k + KW'(1);
          if (match && (cnt != 16'hFFFF)) cnt <= cnt + 16'd1;
        end
        WRITE: count <= cnt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_pattern_scanner.sv
// Scoreboard bench for mem_pattern_scanner: directed cases plus random a/b strings
// checked against a substring-counting reference model.
module tb_mem_pattern_scanner;

  localparam int unsigned MAX_PAT  = 8;
  localparam int unsigned MAX_TEXT = 255;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] Read_data, Address, Write_data;
  logic        MemRead, MemWrite, busy, done;
  logic [15:0] count;

  logic [31:0] mem [256];

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int unsigned cnt;
    int unsigned start_cyc;
    int unsigned lat;
    bit          chk_lat;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned done_cnt = 0;
  int unsigned cyc = 0;
  int          checks = 0;
  int          errors = 0;

  mem_pattern_scanner #(
    .TEXT_BASE  (32'h000),
    .PAT_BASE   (32'h200),
    .RESULT_ADDR(32'h3FC),
    .MAX_PAT    (MAX_PAT),
    .MAX_TEXT   (MAX_TEXT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .Read_data (Read_data),
    .Address   (Address),
    .Write_data(Write_data),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign Read_data = mem[Address[9:2]];
  always @(posedge clk) if (MemWrite) mem[Address[9:2]] <= Write_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference: count every start position where the (truncated) pattern equals the text slice.
  function automatic int unsigned ref_count(input bq_t t, input bq_t p);
    int unsigned pl, tl, n;
    bit ok;
    pl = (p.size() > MAX_PAT) ? MAX_PAT : p.size();
    tl = (t.size() > MAX_TEXT) ? MAX_TEXT : t.size();
    n  = 0;
    if (pl == 0) return 0;
    for (int unsigned i = 0; i + pl <= tl; i++) begin
      ok = 1'b1;
      for (int unsigned m = 0; m < pl; m++) if (t[i + m] != p[m]) ok = 1'b0;
      if (ok) n++;
    end
    return n;
  endfunction

  task automatic load(input bq_t t, input bq_t p);
    for (int i = 0; i < t.size(); i++) mem[i] = {24'($urandom), t[i]};
    mem[t.size()] = {24'($urandom), 8'h00};
    for (int i = 0; i < p.size(); i++) mem[128 + i] = {24'($urandom), p[i]};
    mem[128 + p.size()] = {24'($urandom), 8'h00};
    mem[255] = 32'hDEAD_BEEF;
  endtask

  task automatic run(input string name, input bq_t t, input bq_t p, input bit mid_start);
    exp_t        e;
    int unsigned pl, tl, d0;
    bit          got;
    load(t, p);
    pl = (p.size() > MAX_PAT) ? MAX_PAT : p.size();
    tl = (t.size() > MAX_TEXT) ? MAX_TEXT : t.size();
    @(negedge clk);
    e.cnt       = ref_count(t, p);
    e.start_cyc = cyc;
    e.lat       = (pl == 0) ? 3 : (pl + 1) + (tl + 1) + 2;
    e.chk_lat   = (p.size() <= MAX_PAT) && (t.size() < MAX_TEXT);
    d0 = done_cnt;
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (mid_start) begin
      repeat (pl + 4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 1000 && !got; i++) begin
      @(negedge clk);
      if (done_cnt != d0) got = 1'b1;
    end
    check({name, " done_seen"}, 32'(got), 32'd1);
    if (!got) exp_q.delete();
    repeat (3) @(negedge clk);
    check({name, " idle_after"}, 32'(busy), 32'd0);
    check({name, " mem_result"}, mem[255], {16'h0000, 16'(e.cnt)});
    check({name, " count_held"}, 32'(count), e.cnt);
  endtask

  // Monitor: checks every write and done pulse against the front of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (MemRead || MemWrite) check("strobe_exclusive", 32'(MemRead && MemWrite), 32'd0);
        if (MemRead) check("addr_aligned", 32'(Address[1:0]), 32'd0);
        if (MemWrite) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", Address, Write_data);
          end else begin
            check("write_addr", Address, 32'h3FC);
            check("write_data", Write_data, {16'h0000, 16'(exp_q[0].cnt)});
          end
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no pulse");
          end else begin
            e = exp_q.pop_front();
            check("count", 32'(count), e.cnt);
            if (e.chk_lat) check("latency", cyc - e.start_cyc, e.lat);
          end
          done_cnt++;
        end
      end
    end
  end

  initial begin
    bq_t t, p;
    int unsigned nreads;
    string t1;
    t1 = "Linux is Not Unix is Unix is Unix";
    for (int i = 0; i < 256; i++) mem[i] = '0;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_Address", Address, 32'd0);
    check("rst_Write_data", Write_data, 32'd0);
    check("rst_MemRead", 32'(MemRead), 32'd0);
    check("rst_MemWrite", 32'(MemWrite), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run("T1", str2q(t1), str2q("Unix"), 1'b0);
    run("T2", str2q("aaaa"), str2q("aa"), 1'b0);
    run("T4", str2q("xabcdefghx"), str2q("abcdefghij"), 1'b0);
    run("longpat", str2q("abc"), str2q("abcd"), 1'b0);
    run("emptytext", str2q(""), str2q("ab"), 1'b0);
    p = {};
    run("T3", str2q("abab"), p, 1'b0);

    // Abort in the middle of SCAN once five text reads have been presented.
    load(str2q(t1), str2q("Unix"));
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nreads = 0;
    for (int i = 0; i < 100 && nreads < 5; i++) begin
      if (MemRead && (Address < 32'h200)) nreads++;
      if (nreads < 5) @(negedge clk);
    end
    check("T5 reads_reached", nreads, 32'd5);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("T5 MemRead_drop", 32'(MemRead), 32'd0);
    check("T5 MemWrite_drop", 32'(MemWrite), 32'd0);
    check("T5 busy_drop", 32'(busy), 32'd0);
    check("T5 count_kept", 32'(count), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check("T5 no_result_write", mem[255], 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    run("T5_rerun", str2q("aaaa"), str2q("aa"), 1'b0);

    run("T6", str2q(t1), str2q("Unix"), 1'b1);

    for (int it = 0; it < 30; it++) begin
      int unsigned tl, pl;
      t  = {};
      p  = {};
      tl = $urandom_range(0, 40);
      pl = (it == 7) ? 0 : $urandom_range(1, 4);
      for (int unsigned i = 0; i < tl; i++) t.push_back(8'(8'h61 + $urandom_range(0, 1)));
      for (int unsigned i = 0; i < pl; i++) p.push_back(8'(8'h61 + $urandom_range(0, 1)));
      run("rand", t, p, 1'b0);
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
